// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding and line levels for the serial bit transmitter
package serial_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: counts CLKS_PER_BIT cycles and pulses bit_done on the last one
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [CW-1:0] cnt_q;
  assign bit_done = cnt_q == CW'(CLKS_PER_BIT - 1);
  // restart on clear, otherwise count 0..CLKS_PER_BIT-1 and roll over at each bit boundary
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= (clear || bit_done) ? '0 : cnt_q + CW'(1);
endmodule

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: frame transmitter (start, data LSB-first, optional parity, stop); parity via SERIAL_BIT_TX_PARITY_EN
module serial_bit_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              busy
);
  localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  tx_state_t         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [IW-1:0]     idx_q;
  logic              ser_q, ser_d, busy_q, bit_done, accept, last_bit;
  assign tx_ready = state_q == IDLE;
  assign accept   = tx_valid && tx_ready;
  assign last_bit = idx_q == IW'(DATA_W - 1);
  assign ser_out  = ser_q;
  assign busy     = busy_q;
  serial_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .bit_done (bit_done)
  );
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
  logic parity_q;
  // even parity of the payload, captured together with the word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      parity_q <= 1'b0;
    else if (accept) parity_q <= ^tx_data;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  // line level implied by the current state; registered below
  always_comb begin
    ser_d = LINE_IDLE;
    case (state_q)
      START:   ser_d = LINE_START;
      DATA:    ser_d = shreg_q[0];
`ifdef SERIAL_BIT_TX_PARITY_EN
      PARITY:  ser_d = parity_q;
`endif
      STOP:    ser_d = LINE_STOP;
      default: ser_d = LINE_IDLE;
    endcase
  end
  // frame sequencer: advances one state per completed bit, shifts payload out LSB-first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      ser_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
    end else begin
      ser_q  <= ser_d;
      busy_q <= state_q != IDLE;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= START;
          shreg_q <= tx_data;
          idx_q   <= '0;
        end
        START: if (bit_done) state_q <= DATA;
        DATA: if (bit_done) begin
          shreg_q <= shreg_q >> 1;
          idx_q   <= last_bit ? '0 : idx_q + IW'(1);
          if (last_bit) state_q <= AFTER_DATA;
        end
        PARITY: if (bit_done) state_q <= STOP;
        STOP: if (bit_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_bit_tx.sv
// tb_serial_bit_tx: table, hand-written and randomized checks against a frame-level model
module tb_serial_bit_tx;
  localparam int W = 8, CPB = 4;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = W + 2 + P, N = NB * CPB;

  logic clk = 0, rst_n = 0;
  logic [W-1:0] tx_data = '0, d1 = '0;
  logic tx_valid = 0, v1 = 0;
  logic tx_ready, ser_out, busy, r1, s1, b1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  serial_bit_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ser_out(ser_out), .busy(busy));

  serial_bit_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1),
    .tx_ready(r1), .ser_out(s1), .busy(b1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model: t = edges since the accepting edge, -1 when no frame
  int t = -1;
  logic exp_bits[$];
  function automatic logic m_ready();
    return t < 0 || t >= N;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) t = -1;
    else if (m_ready() && tx_valid) begin
      exp_bits.delete();
      exp_bits.push_back(1'b0);
      for (int i = 0; i < W; i++) exp_bits.push_back(tx_data[i]);
      if (P == 1) exp_bits.push_back(^tx_data);
      exp_bits.push_back(1'b1);
      t = 0;
    end else if (t >= 0) t = t > N ? -1 : t + 1;

  always @(negedge clk) begin
    logic act;
    act = t >= 1 && t <= N;
    chk("m_ready", tx_ready, m_ready());
    chk("m_busy", busy, act);
    if (act) chk("m_ser", ser_out, exp_bits[(t-1)/CPB]);
    else     chk("m_ser_idle", ser_out, 1'b1);
  end

  typedef struct { logic [7:0] data; logic par; } vec_t;
  vec_t tbl[6];

  // send one word with a one-cycle valid and check each bit at its centre plus frame length
  task automatic frame(input logic [7:0] d, input logic par);
    logic line[NB];
    int n;
    line[0] = 1'b0;
    for (int i = 0; i < W; i++) line[i+1] = d[i];
    line[W+1] = par;
    line[NB-1] = 1'b1;
    tx_data = d; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0; tx_data = ~d;
    chk("hs_ready", tx_ready, 1'b0);
    n = 0;
    for (int b = 0; b < NB; b++) begin
      repeat (b == 0 ? 1 + CPB/2 : CPB) begin @(negedge clk); n++; end
      chk("tbl_bit", ser_out, line[b]);
    end
    while (!tx_ready && n < N + 10) begin @(negedge clk); n++; end
    chk("tbl_len", n, N);
  endtask

  initial begin
    int first, second, k;
    logic pb;
    logic exp81[NB];
`ifdef SERIAL_BIT_TX_PARITY_EN
    exp81 = '{0,1,0,0,0,0,0,0,1,0,1};
`else
    exp81 = '{0,1,0,0,0,0,0,0,1,1};
`endif
    tbl[0] = '{8'hA5, 1'b0};
    tbl[1] = '{8'h07, 1'b1};
    tbl[2] = '{8'h3C, 1'b0};
    tbl[3] = '{8'h5B, 1'b1};
    tbl[4] = '{8'h81, 1'b0};
    tbl[5] = '{8'h01, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_ser", ser_out, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1;
    repeat (20) @(negedge clk);
    foreach (tbl[i]) frame(tbl[i].data, tbl[i].par);
    @(negedge clk);
    // back-to-back with valid held high: busy rises exactly N+1 cycles apart
    tx_data = 8'h3C; tx_valid = 1;
    @(negedge clk);
    tx_data = 8'hC3;
    first = -1; second = -1; pb = busy;
    for (k = 1; k < 3*N && second < 0; k++) begin
      @(negedge clk);
      if (busy && !pb) begin
        if (first < 0) first = k; else begin second = k; tx_valid = 0; end
      end
      pb = busy;
    end
    tx_valid = 0;
    chk("b2b_gap", second - first, N + 1);
    k = 0;
    while (!tx_ready && k < 2*N) begin @(negedge clk); k++; end
    chk("b2b_done", tx_ready, 1'b1);
    @(negedge clk);
    // async abort during data bit 3 of 8'hFF
    tx_data = 8'hFF; tx_valid = 1;
    @(negedge clk);
    tx_valid = 0;
    repeat (4*CPB + 2) @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("abort_ser", ser_out, 1'b1);
    chk("abort_ready", tx_ready, 1'b1);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    frame(8'h00, 1'b0);
    @(negedge clk);
    // one clock per bit on the second instance
    d1 = 8'h81; v1 = 1;
    @(negedge clk);
    v1 = 0;
    chk("c1_ready", r1, 1'b0);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      chk("c1_bit", s1, exp81[b]);
    end
    @(negedge clk);
    chk("c1_idle_ready", r1, 1'b1);
    chk("c1_idle_ser", s1, 1'b1);
    // randomized traffic, checked cycle by cycle by the model
    for (int c = 0; c < 1500; c++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
      @(negedge clk);
    end
    tx_valid = 0;
    repeat (N + 4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
